// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache, grouped as one bus.
// master drives requests and memory responses; slave is the cache itself.
interface icache_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTR_WIDTH   = 32
);
  logic [ADDRESS_WIDTH-1:0] i_pc;
  logic                     i_instr_rd;
  logic                     i_flush;
  logic [INSTR_WIDTH-1:0]   o_instr;
  logic                     o_icache_done;
  logic                     o_busy;
  logic                     o_mem_rd;
  logic [ADDRESS_WIDTH-1:0] o_mem_addr;
  logic [INSTR_WIDTH-1:0]   i_mem_data;
  logic                     i_mem_valid;

  modport master (
    output i_pc, i_instr_rd, i_flush, i_mem_data, i_mem_valid,
    input  o_instr, o_icache_done, o_busy, o_mem_rd, o_mem_addr
  );

  modport slave (
    input  i_pc, i_instr_rd, i_flush, i_mem_data, i_mem_valid,
    output o_instr, o_icache_done, o_busy, o_mem_rd, o_mem_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache; misses refill a whole line word-serially
// starting at word 0, then answer the stalled fetch from the freshly written line.
module icache #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int INSTR_WIDTH    = 32,
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic     i_clk,
  input  logic     i_rst,
  icache_if.slave  bus
);
  localparam int OB   = $clog2(WORDS_PER_LINE);
  localparam int IB   = $clog2(NUM_LINES);
  localparam int TAGW = ADDRESS_WIDTH - IB - OB - 2;
  localparam logic [OB-1:0] LAST_WORD = OB'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

  state_t                 state;
  logic [INSTR_WIDTH-1:0] data_mem [NUM_LINES][WORDS_PER_LINE];
  logic [TAGW-1:0]        tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0]   valid;

  logic [TAGW-1:0]          req_tag;
  logic [IB-1:0]            req_idx;
  logic [OB-1:0]            req_off;
  logic [OB-1:0]            cnt;
  logic [OB-1:0]            cnt_next;
  logic                     flush_seen;
  logic [INSTR_WIDTH-1:0]   instr_q;
  logic                     done_q;
  logic                     busy_q;
  logic                     mem_rd_q;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q;

  logic [OB-1:0]   pc_off;
  logic [IB-1:0]   pc_idx;
  logic [TAGW-1:0] pc_tag;
  logic            hit;
  logic            fill_we;
  logic            unused_pc_bits;

  assign pc_off         = bus.i_pc[OB+1:2];
  assign pc_idx         = bus.i_pc[IB+OB+1:OB+2];
  assign pc_tag         = bus.i_pc[ADDRESS_WIDTH-1:IB+OB+2];
  assign unused_pc_bits = ^bus.i_pc[1:0];

  // A flush in the same cycle as a request forces a miss.
  assign hit      = valid[pc_idx] && (tag_mem[pc_idx] == pc_tag) && !bus.i_flush;
  assign fill_we  = (state == REFILL) && bus.i_mem_valid;
  assign cnt_next = cnt + OB'(1);

  assign bus.o_instr       = instr_q;
  assign bus.o_icache_done = done_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_mem_rd      = mem_rd_q;
  assign bus.o_mem_addr    = mem_addr_q;

  // Line storage is not reset; the valid bits alone decide whether it is usable.
  always_ff @(posedge i_clk) begin
    if (fill_we) begin
      data_mem[req_idx][cnt] <= bus.i_mem_data;
      if (cnt == LAST_WORD) tag_mem[req_idx] <= req_tag;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      valid      <= '0;
      req_tag    <= '0;
      req_idx    <= '0;
      req_off    <= '0;
      cnt        <= '0;
      flush_seen <= 1'b0;
      instr_q    <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      if (bus.i_flush) valid <= '0;
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.i_instr_rd) begin
            if (hit) begin
              instr_q <= data_mem[pc_idx][pc_off];
              done_q  <= 1'b1;
            end else begin
              req_tag    <= pc_tag;
              req_idx    <= pc_idx;
              req_off    <= pc_off;
              cnt        <= '0;
              flush_seen <= 1'b0;
              busy_q     <= 1'b1;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= {pc_tag, pc_idx, {OB{1'b0}}, 2'b00};
              state      <= REFILL;
            end
          end
        end
        REFILL: begin
          if (bus.i_flush) flush_seen <= 1'b1;
          if (bus.i_mem_valid) begin
            cnt        <= cnt_next;
            mem_addr_q <= {req_tag, req_idx, cnt_next, 2'b00};
            if (cnt == LAST_WORD) begin
              // A flush seen at any point of the refill leaves the line invalid.
              if (!flush_seen && !bus.i_flush) valid[req_idx] <= 1'b1;
              mem_rd_q <= 1'b0;
              state    <= RESP;
            end
          end
        end
        RESP: begin
          instr_q <= data_mem[req_idx][req_off];
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
